// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: lets the I-cache and D-cache miss engines take turns on one
// AXI4 read channel pair (AR + R). One requester holds the grant from its AR
// handshake through the R beat that carries rlast.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_ar*, i_r*         instruction-cache requester (ar in, r out, rready in)
//   d_ar*, d_r*         data-cache requester (same shape as i_*)
//   m_ar*, m_r*         bus side (ar out registered, r in, rready out)
//   busy                high whenever a grant is outstanding (state != IDLE)
//
// Parameters: ADDR_W, DATA_W, D_FIRST (1 = D wins a tie, 0 = I wins a tie).
//
// Optional build macro ARB_ROUND_ROBIN_EN: a tie goes to the requester that was
// not granted last (last_grant register, reset to I). D_FIRST is then ignored.
module axi_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int D_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  // requester I
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,
  // requester D
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rvalid,
  input  logic              d_rready,
  // bus
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, AR_I, R_I, AR_D, R_D} state_t;

  state_t state, state_n;
  logic   pick_i, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = I was granted last, 1 = D was granted last

  // On a tie the side that did not win last time goes first.
  assign pick_d = d_arvalid & (~i_arvalid | ~last_grant);
`else
  assign pick_d = d_arvalid & (~i_arvalid | (D_FIRST != 0));
`endif
  assign pick_i = i_arvalid & ~pick_d;

  // State register plus the registered AR payload toward the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arvalid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (pick_d) begin
            m_araddr  <= d_araddr;
            m_arlen   <= d_arlen;
            m_arsize  <= d_arsize;
            m_arvalid <= 1'b1;
          end else if (pick_i) begin
            m_araddr  <= i_araddr;
            m_arlen   <= i_arlen;
            m_arsize  <= i_arsize;
            m_arvalid <= 1'b1;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (pick_d)      last_grant <= 1'b1;
          else if (pick_i) last_grant <= 1'b0;
`endif
        end
        AR_I, AR_D: if (m_arready) m_arvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next state and the combinational channel steering.
  always_comb begin
    state_n   = state;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    m_rready  = 1'b0;
    // Data is shared; only the granted side ever sees rvalid.
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_d)      state_n = AR_D;
        else if (pick_i) state_n = AR_I;
      end
      AR_I: begin
        i_arready = m_arvalid & m_arready;
        if (m_arvalid & m_arready) state_n = R_I;
      end
      AR_D: begin
        d_arready = m_arvalid & m_arready;
        if (m_arvalid & m_arready) state_n = R_D;
      end
      R_I: begin
        i_rvalid = m_rvalid;
        i_rlast  = m_rlast;
        m_rready = i_rready;
        // Only the bus rlast closes the grant; arlen is not counted here.
        if (m_rvalid & i_rready & m_rlast) state_n = IDLE;
      end
      R_D: begin
        d_rvalid = m_rvalid;
        d_rlast  = m_rlast;
        m_rready = d_rready;
        if (m_rvalid & d_rready & m_rlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read-address/read-data channel pair between the instruction cache (requester I) and the data cache (requester D).
- Sits between the two cache miss engines and the bus bridge.
- Grants one requester at a time and holds the grant from AR handshake through the R beat carrying rlast.
- Supports burst refills (arlen up to 255) and single-beat uncached reads.

Parameters:
ADDR_W, 32, address width of ar channels
DATA_W, 32, read data width
D_FIRST, 1, default priority: 1 = D wins simultaneous requests, 0 = I wins

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_araddr  in  ADDR_W  I read address
i_arlen  in  8  I burst length-1
i_arsize  in  3  I beat size
i_arvalid  in  1  I address valid
i_arready  out  1  I address accepted
i_rdata  out  DATA_W  I read data
i_rlast  out  1  I last beat
i_rvalid  out  1  I data valid
i_rready  in  1  I data ready
d_araddr, d_arlen, d_arsize, d_arvalid, d_arready, d_rdata, d_rlast, d_rvalid, d_rready: same as i_*, for D
m_araddr  out  ADDR_W  bus address
m_arlen  out  8  bus burst length-1
m_arsize  out  3  bus beat size
m_arvalid  out  1  bus address valid
m_arready  in  1  bus address accepted
m_rdata  in  DATA_W  bus data
m_rlast  in  1  bus last beat
m_rvalid  in  1  bus data valid
m_rready  out  1  bus data ready
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst).
- Reset values:
  - state=IDLE.
  - Registered outputs are 0: m_araddr, m_arlen, m_arsize, m_arvalid.
  - Combinational outputs are 0 while in IDLE/after reset: i_arready, d_arready, i_rvalid, d_rvalid, m_rready, busy.
- States: IDLE, AR_I, R_I, AR_D, R_D.
- IDLE:
  - Samples i_arvalid/d_arvalid.
  - If both are high, priority is per D_FIRST (or the round-robin pointer, see Optional Feature).
  - In the winner's AR_x state, the winner's ar fields are registered into m_ar* and m_arvalid is set to 1 on the next edge. Latency from request to m_arvalid is 1 cycle.
- AR_x:
  - m_arvalid is held with stable payload until m_arready.
  - x_arready = m_arvalid & m_arready, combinational, one cycle only.
  - On handshake: m_arvalid<=0, go to R_x.
- R_x:
  - Combinational pass-through: x_rdata=m_rdata, x_rvalid=m_rvalid, x_rlast=m_rlast, m_rready=x_rready.
  - The other requester sees rvalid=0 and arready=0.
  - On m_rvalid & m_rready & m_rlast, go to IDLE.
  - A new grant may not be issued in the same cycle. Minimum 1 idle cycle between transactions.
- Requester contract:
  - The requester holds arvalid and its payload until arready.
  - The requester may not drop arvalid while pending. The arbiter does not check this.
- Beats without rlast never end the grant, whatever arlen says.
- A requester losing arbitration keeps waiting. No starvation bound in fixed-priority mode.
- rst mid-transaction:
  - Returns to IDLE immediately and drops all valids.
  - The in-flight bus burst is abandoned. System reset also resets the bus, so no drain is required.
- busy=1 in AR_x and R_x.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register (reset 0 = I) decides simultaneous requests: the requester not granted last wins.
  - last_grant updates when a grant is issued.
  - D_FIRST is ignored.
- Undefined: fixed priority per D_FIRST; no last_grant register.

Test Plan:
- Only I requests addr 0x1FC0_0040, arlen=7, m_arready after 2 cycles, 8 beats with rlast on 8th:
  - m_araddr=0x1FC0_0040, m_arlen=7 one cycle after request.
  - i_arready pulses once.
  - i_rvalid on 8 beats with data passed unchanged.
  - Returns to IDLE; busy=0 the cycle after the last beat.
- I and D request the same cycle, D_FIRST=1, macro undefined:
  - D burst completes first; I is then granted after 1 idle cycle.
  - d_rvalid never overlaps i_rvalid.
- Same stimulus repeated 3 times with ARB_ROUND_ROBIN_EN defined: grant order D, I, D, I, D, I.
- D single read arlen=0, i_arvalid rises during R_D: I is not granted until D's rlast beat completes; i_arready stays 0 throughout.
- Backpressure: i_rready low for 3 cycles mid-burst:
  - m_rready low for those 3 cycles.
  - No beat lost or duplicated.
  - Beat count equals arlen+1.
- rst asserted during R_I beat 4: next cycle state=IDLE, m_arvalid=0, m_rready=0, i_rvalid=0, busy=0.
